// File: rtl/zbt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : zbt_pkg                                                      |
// | Shared definitions for the ZBT point writer: data word width,          |
// | default point table contents, sequencer state encoding and the         |
// | point packing helper.                                                  |
// | Revision: 1.0  initial release                                         |
// +----------------------------------------------------------------------+
package zbt_pkg;

  localparam int ZBT_DATA_W = 36;

  // Default point table, loaded into entries 0..3 on reset.
  localparam int DEF_X0 = 300;
  localparam int DEF_Y0 = 300;
  localparam int DEF_C0 = 'h3FC;
  localparam int DEF_X1 = 300;
  localparam int DEF_Y1 = 300;
  localparam int DEF_C1 = 'h0FC;
  localparam int DEF_X2 = 500;
  localparam int DEF_Y2 = 500;
  localparam int DEF_C2 = 'h0FC;
  localparam int DEF_X3 = 400;
  localparam int DEF_Y3 = 400;
  localparam int DEF_C3 = 'h1FC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_WRITE = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Entries beyond the four defaults reset to zero.
  function automatic int def_x(input int k);
    case (k)
      0:       return DEF_X0;
      1:       return DEF_X1;
      2:       return DEF_X2;
      3:       return DEF_X3;
      default: return 0;
    endcase
  endfunction

  function automatic int def_y(input int k);
    case (k)
      0:       return DEF_Y0;
      1:       return DEF_Y1;
      2:       return DEF_Y2;
      3:       return DEF_Y3;
      default: return 0;
    endcase
  endfunction

  function automatic int def_c(input int k);
    case (k)
      0:       return DEF_C0;
      1:       return DEF_C1;
      2:       return DEF_C2;
      3:       return DEF_C3;
      default: return 0;
    endcase
  endfunction

  // Inputs arrive zero-extended to the full word; fields land as
  // {zeros, x, y, colour} from MSB to LSB.
  function automatic logic [ZBT_DATA_W-1:0] pack_point(
    input logic [ZBT_DATA_W-1:0] x,
    input logic [ZBT_DATA_W-1:0] y,
    input logic [ZBT_DATA_W-1:0] c,
    input int                    coord_w,
    input int                    color_w
  );
    return (x << (coord_w + color_w)) | (y << color_w) | c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/zbt_write_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : zbt_write_pipe                                               |
// | LAT-deep delay line aligning write data with the ZBT data phase.       |
// | Cycles without a write carry zero; reset flushes every stage.          |
// | Ports   : clk, reset, valid_i (write issued), data_i (packed word),    |
// |           data_o (word for the write issued LAT cycles earlier)        |
// | Revision: 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module zbt_write_pipe #(
  parameter int LAT = 2,
  parameter int W   = 36
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] stage_q [LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LAT; k++) stage_q[k] <= '0;
    end else begin
      stage_q[0] <= valid_i ? data_i : '0;
      for (int k = 1; k < LAT; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign data_o = stage_q[LAT-1];

endmodule
`default_nettype wire

// File: rtl/zbt_point_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : zbt_point_writer                                             |
// | Loadable point table plus a burst sequencer that writes the first      |
// | 'count' entries into ZBT SRAM at BASE_ADDR+i under arbiter grants.     |
// | Optional macro ZBT_CLEAR_EN: zero CLEAR_LEN words before the points.   |
// | Ports   : clk, reset (sync, active-high)                               |
// |           tbl_we/tbl_idx/tbl_x/tbl_y/tbl_color : table load (IDLE)     |
// |           start/count     : burst request, count latched on start      |
// |           zbt_grant       : arbiter write grant                        |
// |           zbt_req/zbt_addr/zbt_we/zbt_data : ZBT write port            |
// |           busy/done       : burst status, done is a 1-cycle pulse      |
// | Revision: 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module zbt_point_writer
  import zbt_pkg::*;
#(
  parameter  int N_ENTRIES = 4,
  parameter  int ADDR_W    = 19,
  parameter  int COORD_W   = 10,
  parameter  int COLOR_W   = 10,
  parameter  int BASE_ADDR = 0,
  parameter  int ZBT_LAT   = 2,
  parameter  int CLEAR_LEN = 1024,
  localparam int IDX_W     = $clog2(N_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tbl_we,
  input  logic [IDX_W-1:0]      tbl_idx,
  input  logic [COORD_W-1:0]    tbl_x,
  input  logic [COORD_W-1:0]    tbl_y,
  input  logic [COLOR_W-1:0]    tbl_color,
  input  logic                  start,
  input  logic [IDX_W:0]        count,
  input  logic                  zbt_grant,
  output logic                  zbt_req,
  output logic [ADDR_W-1:0]     zbt_addr,
  output logic                  zbt_we,
  output logic [ZBT_DATA_W-1:0] zbt_data,
  output logic                  busy,
  output logic                  done
);

  localparam int CLR_W = $clog2(CLEAR_LEN) + 1;
  localparam int DRN_W = $clog2(ZBT_LAT) + 1;

  logic [COORD_W-1:0] tbl_x_q [N_ENTRIES];
  logic [COORD_W-1:0] tbl_y_q [N_ENTRIES];
  logic [COLOR_W-1:0] tbl_c_q [N_ENTRIES];

  state_t            state_q, state_d;
  logic [IDX_W:0]    cnt_q, cnt_d;
  logic [IDX_W:0]    idx_q, idx_d;
  logic [CLR_W-1:0]  clr_q, clr_d;
  logic [DRN_W-1:0]  drn_q, drn_d;
  logic              zdone_q, zdone_d;
  logic [ZBT_DATA_W-1:0] pipe_data;
  logic [IDX_W-1:0]  ent;

  assign ent = idx_q[IDX_W-1:0];

  // Table only accepts writes in IDLE so a running burst sees a frozen table.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_ENTRIES; k++) begin
        tbl_x_q[k] <= COORD_W'(def_x(k));
        tbl_y_q[k] <= COORD_W'(def_y(k));
        tbl_c_q[k] <= COLOR_W'(def_c(k));
      end
    end else if (tbl_we && (state_q == ST_IDLE)) begin
      tbl_x_q[tbl_idx] <= tbl_x;
      tbl_y_q[tbl_idx] <= tbl_y;
      tbl_c_q[tbl_idx] <= tbl_color;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      clr_q   <= '0;
      drn_q   <= '0;
      zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      clr_q   <= clr_d;
      drn_q   <= drn_d;
      zdone_q <= zdone_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    clr_d     = clr_q;
    drn_d     = drn_q;
    zdone_d   = 1'b0;
    zbt_req   = 1'b0;
    zbt_we    = 1'b0;
    zbt_addr  = '0;
    pipe_data = '0;
    busy      = (state_q != ST_IDLE);
    // A zero-length burst reports completion through its own register
    // so that busy never rises for it.
    done      = zdone_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count == '0) begin
            zdone_d = 1'b1;
          end else begin
            cnt_d = (count > (IDX_W+1)'(N_ENTRIES)) ? (IDX_W+1)'(N_ENTRIES) : count;
            idx_d = '0;
            clr_d = '0;
            drn_d = '0;
`ifdef ZBT_CLEAR_EN
            state_d = ST_CLEAR;
`else
            state_d = ST_WRITE;
`endif
          end
        end
      end

      ST_CLEAR: begin
        zbt_req = 1'b1;
        if (zbt_grant) begin
          zbt_we   = 1'b1;
          zbt_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(clr_q);
          if (clr_q == CLR_W'(CLEAR_LEN - 1)) begin
            state_d = ST_WRITE;
          end else begin
            clr_d = clr_q + 1'b1;
          end
        end
      end

      ST_WRITE: begin
        zbt_req = 1'b1;
        if (zbt_grant) begin
          zbt_we    = 1'b1;
          zbt_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
          pipe_data = pack_point(ZBT_DATA_W'(tbl_x_q[ent]), ZBT_DATA_W'(tbl_y_q[ent]),
                                 ZBT_DATA_W'(tbl_c_q[ent]), COORD_W, COLOR_W);
          if (idx_q == cnt_q - 1'b1) begin
            drn_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        // The last drain cycle coincides with the final word on zbt_data.
        if (drn_q == DRN_W'(ZBT_LAT - 1)) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  zbt_write_pipe #(
    .LAT (ZBT_LAT),
    .W   (ZBT_DATA_W)
  ) u_pipe (
    .clk     (clk),
    .reset   (reset),
    .valid_i (zbt_we),
    .data_i  (pipe_data),
    .data_o  (zbt_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_zbt_point_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_zbt_point_writer                                          |
// | Self-checking bench for zbt_point_writer with a behavioural model of   |
// | the point table and the expected ZBT write stream.                     |
// | Honours ZBT_CLEAR_EN (CLEAR_LEN=8) when the design is built with it.   |
// | Revision: 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module tb_zbt_point_writer;

  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int CLR = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        tbl_we;
  logic [1:0]  tbl_idx;
  logic [9:0]  tbl_x, tbl_y, tbl_color;
  logic        start;
  logic [2:0]  count;
  logic        zbt_grant;
  logic        zbt_req;
  logic [18:0] zbt_addr;
  logic        zbt_we;
  logic [35:0] zbt_data;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_bad = 0;

  logic [9:0] mx [N];
  logic [9:0] my [N];
  logic [9:0] mc [N];

  zbt_point_writer #(
    .N_ENTRIES (N),
    .ADDR_W    (19),
    .COORD_W   (10),
    .COLOR_W   (10),
    .BASE_ADDR (0),
    .ZBT_LAT   (LAT),
    .CLEAR_LEN (CLR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tbl_we    (tbl_we),
    .tbl_idx   (tbl_idx),
    .tbl_x     (tbl_x),
    .tbl_y     (tbl_y),
    .tbl_color (tbl_color),
    .start     (start),
    .count     (count),
    .zbt_grant (zbt_grant),
    .zbt_req   (zbt_req),
    .zbt_addr  (zbt_addr),
    .zbt_we    (zbt_we),
    .zbt_data  (zbt_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_defaults();
    mx[0] = 10'd300; my[0] = 10'd300; mc[0] = 10'h3FC;
    mx[1] = 10'd300; my[1] = 10'd300; mc[1] = 10'h0FC;
    mx[2] = 10'd500; my[2] = 10'd500; mc[2] = 10'h0FC;
    mx[3] = 10'd400; my[3] = 10'd400; mc[3] = 10'h1FC;
  endtask

  task automatic load_entry(input int idx, input logic [9:0] x, input logic [9:0] y,
                            input logic [9:0] c);
    @(posedge clk); #1;
    tbl_we = 1'b1; tbl_idx = 2'(idx); tbl_x = x; tbl_y = y; tbl_color = c;
    @(posedge clk); #1;
    tbl_we = 1'b0;
    mx[idx] = x; my[idx] = y; mc[idx] = c;
  endtask

  task automatic test_reset();
    @(posedge clk); #5;
    n_vec++; if (zbt_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%b want=0", zbt_req); end
    n_vec++; if (zbt_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got=%b want=0", zbt_we); end
    n_vec++; if (zbt_addr !== 19'd0) begin n_bad++; $display("FAIL reset_addr got=%h want=0", zbt_addr); end
    n_vec++; if (zbt_data !== 36'd0) begin n_bad++; $display("FAIL reset_data got=%h want=0", zbt_data); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
  endtask

  // Runs one burst. pct<0 selects an alternating 1,0,1,... grant pattern;
  // inject pulses start and tbl_we while the burst is running.
  task automatic test_burst(input int cnt, input int pct, input bit inject);
    logic [18:0] ea [$];
    logic [35:0] ew [$];
    logic [35:0] pm [$];
    logic [35:0] exp_d;
    int npt, total, n_we, done_cyc;
    bit g, exp_we, exp_busy, fin;
    npt = (cnt > N) ? N : cnt;
`ifdef ZBT_CLEAR_EN
    if (npt > 0) for (int k = 0; k < CLR; k++) begin ea.push_back(19'(k)); ew.push_back(36'd0); end
`endif
    for (int k = 0; k < npt; k++) begin
      ea.push_back(19'(k));
      ew.push_back({6'b0, mx[k], my[k], mc[k]});
    end
    total = ea.size();
    for (int k = 0; k < LAT; k++) pm.push_back(36'd0);
    done_cyc = (total == 0) ? 0 : -1;
    n_we = 0;
    fin = 1'b0;

    @(posedge clk); #1;
    start = 1'b1; count = 3'(cnt); zbt_grant = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      g = (pct < 0) ? (cyc % 2 == 0) : ($urandom_range(0, 99) < pct);
      zbt_grant = g;
      if (inject && (cyc == 1 || cyc == 2)) begin
        start = 1'b1; count = 3'd2;
        tbl_we = 1'b1; tbl_idx = 2'($urandom); tbl_x = 10'($urandom);
        tbl_y = 10'($urandom); tbl_color = 10'($urandom);
      end else begin
        start = 1'b0; tbl_we = 1'b0;
      end
      #4;
      exp_d  = pm.pop_front();
      exp_we = g && (n_we < total);
      if (total == 0) exp_busy = 1'b0;
      else exp_busy = (done_cyc < 0) || (cyc < done_cyc);

      n_vec++; if (zbt_data !== exp_d) begin
        n_bad++; $display("FAIL data cyc=%0d got=%h want=%h", cyc, zbt_data, exp_d); end
      n_vec++; if (zbt_we !== exp_we) begin
        n_bad++; $display("FAIL we cyc=%0d got=%b want=%b", cyc, zbt_we, exp_we); end
      n_vec++; if (zbt_req !== (n_we < total)) begin
        n_bad++; $display("FAIL req cyc=%0d got=%b want=%b", cyc, zbt_req, (n_we < total)); end
      n_vec++; if (done !== (cyc == done_cyc)) begin
        n_bad++; $display("FAIL done cyc=%0d got=%b want=%b", cyc, done, (cyc == done_cyc)); end
      if (cyc != done_cyc || total == 0) begin
        n_vec++; if (busy !== exp_busy) begin
          n_bad++; $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy); end
      end
      if (exp_we) begin
        n_vec++; if (zbt_addr !== ea[n_we]) begin
          n_bad++; $display("FAIL addr cyc=%0d got=%h want=%h", cyc, zbt_addr, ea[n_we]); end
        pm.push_back(ew[n_we]);
        n_we++;
        if (n_we == total) done_cyc = cyc + LAT;
      end else begin
        pm.push_back(36'd0);
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) begin
        fin = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_vec++; if (!fin) begin
      n_bad++; $display("FAIL burst_timeout got=writes %0d want=%0d", n_we, total); end
    zbt_grant = 1'b0; start = 1'b0; tbl_we = 1'b0;
  endtask

  task automatic test_defaults();
    test_burst(4, 100, 1'b0);
  endtask

  task automatic test_load_stall();
    load_entry(1, 10'd12, 10'd34, 10'h155);
    test_burst(2, -1, 1'b0);
  endtask

  task automatic test_zero_count();
    test_burst(0, 100, 1'b0);
  endtask

  task automatic test_clamp_ignore();
    test_burst(7, 100, 1'b1);
    test_burst(4, 100, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1'b1; count = 3'd4; zbt_grant = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    #4;
    n_vec++; if (zbt_we !== 1'b1 || zbt_addr !== 19'd0) begin
      n_bad++; $display("FAIL mid_first_write got=%b/%h want=1/0", zbt_we, zbt_addr); end
    @(posedge clk); #1;
    reset = 1'b1;
    #4;
    n_vec++; if (zbt_we !== 1'b1 || zbt_addr !== 19'd1) begin
      n_bad++; $display("FAIL mid_second_write got=%b/%h want=1/1", zbt_we, zbt_addr); end
    @(posedge clk); #1;
    reset = 1'b0;
    #4;
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got=%b want=0", busy); end
    n_vec++; if (zbt_we !== 1'b0) begin n_bad++; $display("FAIL mid_we got=%b want=0", zbt_we); end
    n_vec++; if (zbt_data !== 36'd0) begin n_bad++; $display("FAIL mid_data got=%h want=0", zbt_data); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL mid_done got=%b want=0", done); end
    zbt_grant = 1'b0;
    model_defaults();
    test_burst(4, 60, 1'b0);
  endtask

  task automatic test_random();
    int nl;
    for (int r = 0; r < 6; r++) begin
      nl = $urandom_range(0, 3);
      for (int k = 0; k < nl; k++)
        load_entry($urandom_range(0, N - 1), 10'($urandom), 10'($urandom), 10'($urandom));
      test_burst($urandom_range(0, 7), $urandom_range(30, 100), 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1; tbl_we = 1'b0; tbl_idx = '0; tbl_x = '0; tbl_y = '0; tbl_color = '0;
    start = 1'b0; count = '0; zbt_grant = 1'b0;
    model_defaults();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_defaults();
    test_load_stall();
    test_zero_count();
    test_clamp_ignore();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
